// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / hazard unit
// and for the datapath forwarding muxes that consume its selects.
package hazard_pkg;

  localparam int FWD_REGFILE = 0;
  localparam int ENT_CTRL_W  = 3;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic is_load;
  } ent_ctrl_t;

  function automatic int sel_w(input int nstages);
    return (nstages < 1) ? 1 : $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / hazard response bundle between the core
// and the forwarding + load-use hazard unit.
interface fwd_hazard_if #(
  parameter int ADDR_W = 5,
  parameter int NSRC   = 2,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 32
);
  logic                     id_valid;
  logic [NSRC*ADDR_W-1:0]   id_src;
  logic [ADDR_W-1:0]        id_dest;
  logic                     id_wb_en;
  logic                     id_is_load;
  logic                     flush;
  logic                     stall_ext;
  logic                     stall_id;
  logic                     bubble_ex;
  logic [NSRC*SEL_W-1:0]    fwd_sel;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output id_valid, id_src, id_dest,
    output id_wb_en, id_is_load,
    output flush, stall_ext,
    input  stall_id, bubble_ex,
    input  fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_dest,
    input  id_wb_en, id_is_load,
    input  flush, stall_ext,
    output stall_id, bubble_ex,
    output fwd_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_shadow_pipe.sv
// Shadow copy of in-flight destinations, EXE (entry 0) through
// the last forwardable stage; holds on freeze.
module fwd_shadow_pipe
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NSRC    = 2,
  parameter int NSTAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hold,
  input  ent_ctrl_t                     in_ctrl,
  input  logic [ADDR_W-1:0]             in_dest,
  input  logic [NSRC*ADDR_W-1:0]        in_src,
  output ent_ctrl_t [NSTAGES:0]         ctrl,
  output logic [NSTAGES:0][ADDR_W-1:0]  dest,
  output logic [NSRC*ADDR_W-1:0]        ex_src
);

  ent_ctrl_t [NSTAGES:0]         ctrl_q, ctrl_d;
  logic [NSTAGES:0][ADDR_W-1:0]  dest_q, dest_d;
  logic [NSRC*ADDR_W-1:0]        src_q, src_d;

  always_comb begin
    ctrl_d = ctrl_q;
    dest_d = dest_q;
    src_d  = src_q;
    if (!hold) begin
      for (int k = NSTAGES; k >= 1; k--) begin
        ctrl_d[k] = ctrl_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
      ctrl_d[0] = in_ctrl;
      dest_d[0] = in_dest;
      src_d     = in_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      dest_q <= '0;
      src_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dest_q <= dest_d;
      src_q  <= src_d;
    end
  end

  assign ctrl   = ctrl_q;
  assign dest   = dest_q;
  assign ex_src = src_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use stall/bubble and a
// saturating stall counter for the EXE stage.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NSRC     = 2,
  parameter int NSTAGES  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fwd_hazard_if.slave bus
);

  localparam int SEL_W = sel_w(NSTAGES);

  ent_ctrl_t [NSTAGES:0]             ctrl;
  logic [NSTAGES:0][ADDR_W-1:0]      dest;
  logic [NSRC*ADDR_W-1:0]            ex_src_flat;
  logic [NSRC-1:0][ADDR_W-1:0]       src_ex;
  logic [NSRC-1:0][ADDR_W-1:0]       src_id;
  logic [NSRC-1:0][SEL_W-1:0]        fwd_sel;
  logic                              haz;
  logic                              stall;
  logic                              accept;
  ent_ctrl_t                         in_ctrl;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              unused_bits;

  function automatic logic hit(
    input ent_ctrl_t         c,
    input logic [ADDR_W-1:0] d,
    input logic [ADDR_W-1:0] s
  );
    return c.valid & c.wb_en & (d == s) & (s != '0);
  endfunction

  assign src_id = bus.id_src;
  assign src_ex = ex_src_flat;

  assign stall  = bus.id_valid & ~bus.flush & haz;
  assign accept = bus.id_valid & ~stall & ~bus.flush;

  // Bubbles are all-zero entries so a stale src never forwards.
  assign in_ctrl.valid   = accept;
  assign in_ctrl.wb_en   = accept & bus.id_wb_en;
  assign in_ctrl.is_load = accept & bus.id_is_load;

  fwd_shadow_pipe #(
    .ADDR_W  (ADDR_W),
    .NSRC    (NSRC),
    .NSTAGES (NSTAGES)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (bus.stall_ext),
    .in_ctrl (in_ctrl),
    .in_dest (accept ? bus.id_dest : '0),
    .in_src  (accept ? bus.id_src : '0),
    .ctrl    (ctrl),
    .dest    (dest),
    .ex_src  (ex_src_flat)
  );

  // Walk oldest to nearest so the nearest producer wins.
  always_comb begin
    fwd_sel = '0;
    haz     = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = NSTAGES; k >= 1; k--) begin
        if (hit(ctrl[k], dest[k], src_ex[i]))
          fwd_sel[i] = SEL_W'(k);
      end
      for (int j = 0; j < LOAD_LAT; j++) begin
        if (hit(ctrl[j], dest[j], src_id[i]) &&
            ctrl[j].is_load)
          haz = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !bus.stall_ext && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.stall_id  = stall;
  assign bus.bubble_ex = stall | bus.flush;
  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall_cnt = cnt_q;

  assign unused_bits = ^{ctrl, dest};

endmodule
